// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall, flush and freeze control.
// Load-use, mispredict and memory-wait handling with counters.
module pipe_hazard_ctrl #(
  parameter logic [1:0] LOAD_SEL     = 2'b01,
  parameter int         FLUSH_CYCLES = 1,
  parameter int         MEM_TIMEOUT  = 255,
  parameter int         CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_written_reg,
  input  logic             ex_reg_write,
  input  logic [1:0]       ex_data_to_reg,
  input  logic [1:0]       ex_branch,
  input  logic             ex_mispredict,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             PC_CE,
  output logic             IF_ID_CE,
  output logic             IF_ID_flush,
  output logic             ID_EXE_CE,
  output logic             ID_EXE_dstall,
  output logic             ID_EXE_cstall,
  output logic             EXE_MEM_CE,
  output logic             MEM_WB_CE,
  output logic             redirect,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cnt_load_use,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_mem_wait
);

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    MEM_WAIT
  } state_t;

  // {PC_CE, IF_ID_CE, IF_ID_flush, ID_EXE_CE,
  //  dstall, cstall, EXE_MEM_CE, MEM_WB_CE, redirect}
  localparam logic [8:0] C_NORM = 9'b1_1_0_1_0_0_1_1_0;
  localparam logic [8:0] C_LU   = 9'b0_0_0_1_1_0_1_1_0;
  localparam logic [8:0] C_MP   = 9'b1_1_1_1_0_1_1_1_1;
  localparam logic [8:0] C_FL   = 9'b1_1_1_1_0_0_1_1_0;
  localparam logic [8:0] C_FRZ  = 9'b0;

  localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [8:0] TO_LIM  = 9'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic [7:0] wait_cnt;
  logic [8:0] ctl;

  logic memwait, mispredict, flush_step;
  logic hit_rs1, hit_rs2, load_use;

  assign memwait    = mem_req & ~dmem_ready;
  assign mispredict = ex_mispredict & (|ex_branch) & ~memwait;
  assign flush_step = (state == FLUSH) & ~memwait & ~mispredict;

  assign hit_rs1 = id_use_rs1 & (id_rs1 == ex_written_reg);
  assign hit_rs2 = id_use_rs2 & (id_rs2 == ex_written_reg);

  // ID is wrong-path during FLUSH, so load-use is ignored there.
  assign load_use = ex_reg_write
                  & (ex_data_to_reg == LOAD_SEL)
                  & (ex_written_reg != 5'd0)
                  & (hit_rs1 | hit_rs2)
                  & ~memwait & ~mispredict
                  & (state != FLUSH);

  assign {PC_CE, IF_ID_CE, IF_ID_flush, ID_EXE_CE,
          ID_EXE_dstall, ID_EXE_cstall,
          EXE_MEM_CE, MEM_WB_CE, redirect} = ctl;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + ONE;
  endfunction

  // Next state and control outputs, highest priority hazard first.
  always_comb begin
    ctl           = C_NORM;
    state_nxt     = RUN;
    flush_cnt_nxt = flush_cnt;
    unique case (1'b1)
      memwait: begin
        ctl       = C_FRZ;
        state_nxt = MEM_WAIT;
      end
      mispredict: begin
        ctl = C_MP;
        if (FLUSH_CYCLES > 1) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FL_LOAD;
        end
      end
      flush_step: begin
        ctl           = C_FL;
        flush_cnt_nxt = flush_cnt - 3'd1;
        if (flush_cnt > 3'd1) begin
          state_nxt = FLUSH;
        end
      end
      load_use: begin
        ctl = C_LU;
      end
      default: begin
        ctl = C_NORM;
      end
    endcase
    if (!rst_n) begin
      ctl = C_FRZ;
    end
  end

  // State and flush countdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Per-access wait length and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else if (memwait) begin
      if (wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if ({1'b0, wait_cnt} + 9'd1 >= TO_LIM) begin
        mem_timeout <= 1'b1;
      end
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_load_use <= '0;
      cnt_flush    <= '0;
      cnt_mem_wait <= '0;
    end else begin
      if (load_use) begin
        cnt_load_use <= sat_inc(cnt_load_use);
      end
      if (mispredict) begin
        cnt_flush <= sat_inc(cnt_flush);
      end
      if (memwait) begin
        cnt_mem_wait <= sat_inc(cnt_mem_wait);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two parameter sets, shared stimulus.
// Expected control words are queued per step and popped at sample time.
module tb_pipe_hazard_ctrl;

  localparam logic [8:0] NORM_V = 9'b110100110;
  localparam logic [8:0] LU_V   = 9'b000110110;
  localparam logic [8:0] MP_V   = 9'b111101111;
  localparam logic [8:0] FL_V   = 9'b111100110;
  localparam logic [8:0] FRZ_V  = 9'b000000000;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] wr;
    logic       rw;
    logic [1:0] dtr;
    logic [1:0] br;
    logic       mp;
    logic       mreq;
    logic       rdy;
    logic [8:0] ea;
    logic [8:0] eb;
  } stim_t;

  typedef struct packed {
    logic [8:0] ea;
    logic [8:0] eb;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_written_reg = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_reg_write = 0;
  logic [1:0] ex_data_to_reg = '0, ex_branch = '0;
  logic ex_mispredict = 0, mem_req = 0, dmem_ready = 1;

  logic pc_a, ifid_a, fl_a, idex_a, ds_a, cs_a, exm_a, mwb_a, rd_a;
  logic pc_b, ifid_b, fl_b, idex_b, ds_b, cs_b, exm_b, mwb_b, rd_b;
  logic mt_a, mt_b;
  logic [31:0] clu_a, cfl_a, cmw_a;
  logic [3:0]  clu_b, cfl_b, cmw_b;
  logic [8:0]  ctl_a, ctl_b;

  assign ctl_a = {pc_a, ifid_a, fl_a, idex_a, ds_a,
                  cs_a, exm_a, mwb_a, rd_a};
  assign ctl_b = {pc_b, ifid_b, fl_b, idex_b, ds_b,
                  cs_b, exm_b, mwb_b, rd_b};

  int total = 0;
  int bad = 0;
  int m_lu_a = 0, m_fl_a = 0, m_mw_a = 0;
  int m_lu_b = 0, m_fl_b = 0, m_mw_b = 0;
  sb_t sb[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .LOAD_SEL(2'b01), .FLUSH_CYCLES(1),
    .MEM_TIMEOUT(255), .CNT_W(32)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_written_reg(ex_written_reg),
    .ex_reg_write(ex_reg_write),
    .ex_data_to_reg(ex_data_to_reg),
    .ex_branch(ex_branch), .ex_mispredict(ex_mispredict),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .PC_CE(pc_a), .IF_ID_CE(ifid_a), .IF_ID_flush(fl_a),
    .ID_EXE_CE(idex_a), .ID_EXE_dstall(ds_a),
    .ID_EXE_cstall(cs_a), .EXE_MEM_CE(exm_a),
    .MEM_WB_CE(mwb_a), .redirect(rd_a),
    .mem_timeout(mt_a), .cnt_load_use(clu_a),
    .cnt_flush(cfl_a), .cnt_mem_wait(cmw_a)
  );

  pipe_hazard_ctrl #(
    .LOAD_SEL(2'b01), .FLUSH_CYCLES(3),
    .MEM_TIMEOUT(5), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_written_reg(ex_written_reg),
    .ex_reg_write(ex_reg_write),
    .ex_data_to_reg(ex_data_to_reg),
    .ex_branch(ex_branch), .ex_mispredict(ex_mispredict),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .PC_CE(pc_b), .IF_ID_CE(ifid_b), .IF_ID_flush(fl_b),
    .ID_EXE_CE(idex_b), .ID_EXE_dstall(ds_b),
    .ID_EXE_cstall(cs_b), .EXE_MEM_CE(exm_b),
    .MEM_WB_CE(mwb_b), .redirect(rd_b),
    .mem_timeout(mt_b), .cnt_load_use(clu_b),
    .cnt_flush(cfl_b), .cnt_mem_wait(cmw_b)
  );

  function automatic stim_t st(logic [8:0] ea, logic [8:0] eb);
    stim_t s = '0;
    s.rst = 1'b1;
    s.rdy = 1'b1;
    s.ea  = ea;
    s.eb  = eb;
    return s;
  endfunction

  function automatic stim_t add_lu(stim_t s);
    s.wr = 5'd5; s.rw = 1'b1; s.dtr = 2'b01;
    s.rs1 = 5'd5; s.u1 = 1'b1;
    s.rs2 = 5'd1; s.u2 = 1'b1;
    return s;
  endfunction

  function automatic stim_t add_mp(stim_t s);
    s.br = 2'b01; s.mp = 1'b1;
    return s;
  endfunction

  function automatic stim_t add_mw(stim_t s);
    s.mreq = 1'b1; s.rdy = 1'b0;
    return s;
  endfunction

  // Drive one step and queue its expected control words.
  task automatic apply(input stim_t s);
    rst_n = s.rst;
    id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2;
    ex_written_reg = s.wr; ex_reg_write = s.rw;
    ex_data_to_reg = s.dtr; ex_branch = s.br;
    ex_mispredict = s.mp;
    mem_req = s.mreq; dmem_ready = s.rdy;
    sb.push_back({s.ea, s.eb});
    if (!s.rst) begin
      m_lu_a = 0; m_fl_a = 0; m_mw_a = 0;
      m_lu_b = 0; m_fl_b = 0; m_mw_b = 0;
    end else begin
      if (s.ea == LU_V)  m_lu_a++;
      if (s.ea == MP_V)  m_fl_a++;
      if (s.ea == FRZ_V) m_mw_a++;
      if (s.eb == LU_V  && m_lu_b < 15) m_lu_b++;
      if (s.eb == MP_V  && m_fl_b < 15) m_fl_b++;
      if (s.eb == FRZ_V && m_mw_b < 15) m_mw_b++;
    end
  endtask

  task automatic test_reset();
    stim_t t[$];
    sb_t e;
    stim_t s;
    for (int k = 0; k < 3; k++) begin
      s = st(FRZ_V, FRZ_V);
      s.rst = 1'b0;
      t.push_back(s);
    end
    t.push_back(st(NORM_V, NORM_V));
    foreach (t[i]) begin
      apply(t[i]); #2;
      e = sb.pop_front();
      total += 3;
      if (ctl_a !== e.ea) begin
        bad++;
        $display("FAIL reset[%0d] ctl_a got=%b want=%b", i, ctl_a, e.ea);
      end
      if (ctl_b !== e.eb) begin
        bad++;
        $display("FAIL reset[%0d] ctl_b got=%b want=%b", i, ctl_b, e.eb);
      end
      if ({mt_a, mt_b, clu_a, cfl_a, cmw_a, clu_b, cfl_b, cmw_b} !== '0) begin
        bad++;
        $display("FAIL reset[%0d] cnt/flag got=%b/%b %0d %0d %0d %0d %0d %0d want=0",
                 i, mt_a, mt_b, clu_a, cfl_a, cmw_a, clu_b, cfl_b, cmw_b);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    stim_t t[$];
    stim_t s;
    sb_t e;
    t.push_back(add_lu(st(LU_V, LU_V)));
    t.push_back(st(NORM_V, NORM_V));
    s = add_lu(st(NORM_V, NORM_V)); s.wr = 0; s.rs1 = 0;
    t.push_back(s);
    s = add_lu(st(NORM_V, NORM_V)); s.u1 = 0; s.u2 = 0;
    t.push_back(s);
    s = add_lu(st(LU_V, LU_V)); s.rs1 = 5'd1; s.rs2 = 5'd5;
    t.push_back(s);
    s = add_lu(st(NORM_V, NORM_V)); s.dtr = 2'b00;
    t.push_back(s);
    s = add_lu(st(NORM_V, NORM_V)); s.rw = 1'b0;
    t.push_back(s);
    t.push_back(st(NORM_V, NORM_V));
    foreach (t[i]) begin
      apply(t[i]); #2;
      e = sb.pop_front();
      total += 2;
      if (ctl_a !== e.ea) begin
        bad++;
        $display("FAIL load_use[%0d] ctl_a got=%b want=%b", i, ctl_a, e.ea);
      end
      if (ctl_b !== e.eb) begin
        bad++;
        $display("FAIL load_use[%0d] ctl_b got=%b want=%b", i, ctl_b, e.eb);
      end
      @(negedge clk);
    end
    total += 2;
    if (clu_a !== 32'(m_lu_a)) begin
      bad++;
      $display("FAIL load_use cnt_a got=%0d want=%0d", clu_a, m_lu_a);
    end
    if (clu_b !== 4'(m_lu_b)) begin
      bad++;
      $display("FAIL load_use cnt_b got=%0d want=%0d", clu_b, m_lu_b);
    end
  endtask

  task automatic test_mispredict();
    stim_t t[$];
    stim_t s;
    sb_t e;
    t.push_back(add_mp(st(MP_V, MP_V)));
    t.push_back(st(NORM_V, FL_V));
    t.push_back(add_lu(st(LU_V, FL_V)));
    t.push_back(st(NORM_V, NORM_V));
    s = st(NORM_V, NORM_V); s.mp = 1'b1;
    t.push_back(s);
    t.push_back(add_mp(st(MP_V, MP_V)));
    t.push_back(add_mp(st(MP_V, MP_V)));
    t.push_back(st(NORM_V, FL_V));
    t.push_back(st(NORM_V, FL_V));
    t.push_back(st(NORM_V, NORM_V));
    foreach (t[i]) begin
      apply(t[i]); #2;
      e = sb.pop_front();
      total += 2;
      if (ctl_a !== e.ea) begin
        bad++;
        $display("FAIL mispredict[%0d] ctl_a got=%b want=%b", i, ctl_a, e.ea);
      end
      if (ctl_b !== e.eb) begin
        bad++;
        $display("FAIL mispredict[%0d] ctl_b got=%b want=%b", i, ctl_b, e.eb);
      end
      @(negedge clk);
    end
    total += 3;
    if (cfl_a !== 32'(m_fl_a)) begin
      bad++;
      $display("FAIL mispredict cnt_flush_a got=%0d want=%0d", cfl_a, m_fl_a);
    end
    if (cfl_b !== 4'(m_fl_b)) begin
      bad++;
      $display("FAIL mispredict cnt_flush_b got=%0d want=%0d", cfl_b, m_fl_b);
    end
    if (clu_b !== 4'(m_lu_b)) begin
      bad++;
      $display("FAIL mispredict cnt_lu_b got=%0d want=%0d", clu_b, m_lu_b);
    end
  endtask

  task automatic test_mem_wait();
    stim_t t[$];
    stim_t s;
    sb_t e;
    t.push_back(add_lu(add_mw(st(FRZ_V, FRZ_V))));
    for (int k = 0; k < 3; k++)
      t.push_back(add_mp(add_mw(st(FRZ_V, FRZ_V))));
    s = add_mp(st(MP_V, MP_V)); s.mreq = 1'b1;
    t.push_back(s);
    t.push_back(st(NORM_V, FL_V));
    t.push_back(st(NORM_V, FL_V));
    t.push_back(st(NORM_V, NORM_V));
    s = st(NORM_V, NORM_V); s.rdy = 1'b0;
    t.push_back(s);
    foreach (t[i]) begin
      apply(t[i]); #2;
      e = sb.pop_front();
      total += 2;
      if (ctl_a !== e.ea) begin
        bad++;
        $display("FAIL mem_wait[%0d] ctl_a got=%b want=%b", i, ctl_a, e.ea);
      end
      if (ctl_b !== e.eb) begin
        bad++;
        $display("FAIL mem_wait[%0d] ctl_b got=%b want=%b", i, ctl_b, e.eb);
      end
      @(negedge clk);
    end
    total += 4;
    if (cmw_a !== 32'(m_mw_a)) begin
      bad++;
      $display("FAIL mem_wait cnt_a got=%0d want=%0d", cmw_a, m_mw_a);
    end
    if (cmw_b !== 4'(m_mw_b)) begin
      bad++;
      $display("FAIL mem_wait cnt_b got=%0d want=%0d", cmw_b, m_mw_b);
    end
    if (clu_a !== 32'(m_lu_a)) begin
      bad++;
      $display("FAIL mem_wait cnt_lu_a got=%0d want=%0d", clu_a, m_lu_a);
    end
    if ({mt_a, mt_b} !== 2'b00) begin
      bad++;
      $display("FAIL mem_wait timeout got=%b%b want=00", mt_a, mt_b);
    end
  endtask

  task automatic test_timeout();
    stim_t t[$];
    stim_t s;
    sb_t e;
    logic want_b;
    for (int k = 0; k < 6; k++)
      t.push_back(add_mw(st(FRZ_V, FRZ_V)));
    for (int k = 0; k < 3; k++) begin
      s = st(NORM_V, NORM_V); s.mreq = 1'b1;
      t.push_back(s);
    end
    s = st(FRZ_V, FRZ_V); s.rst = 1'b0;
    t.push_back(s);
    t.push_back(st(NORM_V, NORM_V));
    foreach (t[i]) begin
      apply(t[i]); #2;
      e = sb.pop_front();
      want_b = (i >= 5 && i <= 8);
      total += 4;
      if (ctl_a !== e.ea) begin
        bad++;
        $display("FAIL timeout[%0d] ctl_a got=%b want=%b", i, ctl_a, e.ea);
      end
      if (ctl_b !== e.eb) begin
        bad++;
        $display("FAIL timeout[%0d] ctl_b got=%b want=%b", i, ctl_b, e.eb);
      end
      if (mt_b !== want_b) begin
        bad++;
        $display("FAIL timeout[%0d] mem_timeout_b got=%b want=%b", i, mt_b, want_b);
      end
      if (mt_a !== 1'b0) begin
        bad++;
        $display("FAIL timeout[%0d] mem_timeout_a got=%b want=0", i, mt_a);
      end
      if (i == 8) begin
        total += 2;
        if (cmw_a !== 32'(m_mw_a)) begin
          bad++;
          $display("FAIL timeout cnt_a got=%0d want=%0d", cmw_a, m_mw_a);
        end
        if (cmw_b !== 4'(m_mw_b)) begin
          bad++;
          $display("FAIL timeout cnt_b got=%0d want=%0d", cmw_b, m_mw_b);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    stim_t t[$];
    stim_t s;
    sb_t e;
    t.push_back(add_mp(st(MP_V, MP_V)));
    s = st(FRZ_V, FRZ_V); s.rst = 1'b0;
    t.push_back(s);
    t.push_back(st(NORM_V, NORM_V));
    t.push_back(add_mw(st(FRZ_V, FRZ_V)));
    s = add_mw(st(FRZ_V, FRZ_V)); s.rst = 1'b0;
    t.push_back(s);
    t.push_back(st(NORM_V, NORM_V));
    foreach (t[i]) begin
      apply(t[i]); #2;
      e = sb.pop_front();
      total += 2;
      if (ctl_a !== e.ea) begin
        bad++;
        $display("FAIL abort[%0d] ctl_a got=%b want=%b", i, ctl_a, e.ea);
      end
      if (ctl_b !== e.eb) begin
        bad++;
        $display("FAIL abort[%0d] ctl_b got=%b want=%b", i, ctl_b, e.eb);
      end
      @(negedge clk);
    end
    total += 1;
    if ({cmw_a, cfl_a, cmw_b, cfl_b} !== '0) begin
      bad++;
      $display("FAIL abort counters got=%0d %0d %0d %0d want=0",
               cmw_a, cfl_a, cmw_b, cfl_b);
    end
  endtask

  task automatic test_simultaneous();
    stim_t t[$];
    sb_t e;
    t.push_back(add_mp(add_lu(st(MP_V, MP_V))));
    t.push_back(st(NORM_V, FL_V));
    t.push_back(st(NORM_V, FL_V));
    t.push_back(st(NORM_V, NORM_V));
    foreach (t[i]) begin
      apply(t[i]); #2;
      e = sb.pop_front();
      total += 2;
      if (ctl_a !== e.ea) begin
        bad++;
        $display("FAIL simul[%0d] ctl_a got=%b want=%b", i, ctl_a, e.ea);
      end
      if (ctl_b !== e.eb) begin
        bad++;
        $display("FAIL simul[%0d] ctl_b got=%b want=%b", i, ctl_b, e.eb);
      end
      @(negedge clk);
    end
    total += 2;
    if (clu_a !== 32'(m_lu_a) || clu_b !== 4'(m_lu_b)) begin
      bad++;
      $display("FAIL simul cnt_lu got=%0d/%0d want=%0d/%0d",
               clu_a, clu_b, m_lu_a, m_lu_b);
    end
    if (cfl_a !== 32'(m_fl_a) || cfl_b !== 4'(m_fl_b)) begin
      bad++;
      $display("FAIL simul cnt_flush got=%0d/%0d want=%0d/%0d",
               cfl_a, cfl_b, m_fl_a, m_fl_b);
    end
  endtask

  task automatic test_saturation();
    stim_t t[$];
    sb_t e;
    for (int k = 0; k < 20; k++) begin
      t.push_back(add_lu(st(LU_V, LU_V)));
      t.push_back(st(NORM_V, NORM_V));
    end
    foreach (t[i]) begin
      apply(t[i]); #2;
      e = sb.pop_front();
      total += 2;
      if (ctl_a !== e.ea) begin
        bad++;
        $display("FAIL sat[%0d] ctl_a got=%b want=%b", i, ctl_a, e.ea);
      end
      if (ctl_b !== e.eb) begin
        bad++;
        $display("FAIL sat[%0d] ctl_b got=%b want=%b", i, ctl_b, e.eb);
      end
      @(negedge clk);
    end
    total += 2;
    if (clu_b !== 4'hF) begin
      bad++;
      $display("FAIL sat cnt_lu_b got=%0d want=15", clu_b);
    end
    if (clu_a !== 32'(m_lu_a)) begin
      bad++;
      $display("FAIL sat cnt_lu_a got=%0d want=%0d", clu_a, m_lu_a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_load_use();
    test_mispredict();
    test_mem_wait();
    test_timeout();
    test_reset_abort();
    test_simultaneous();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32I core.
- Drives clock-enables, bubble (dstall) and flush (cstall) controls for PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- Resolves three hazard classes: load-use data hazards, branch mispredicts resolved in EXE, and multi-cycle data-memory waits.
- Keeps saturating performance counters for stall and flush events.

Parameters:
- LOAD_SEL, 2'b01: data_to_reg encoding that marks a load in ID/EXE.
- FLUSH_CYCLES, 1: IF/ID flush cycles per mispredict, range 1..7.
- MEM_TIMEOUT, 255: dmem_ready-low cycles before mem_timeout sets, range 1..255.
- CNT_W, 32: width of each performance counter.

Ports:
- clk, in, 1: clock; all state updates on posedge.
- rst_n, in, 1: asynchronous, active-low reset.
- id_rs1, in, 5: rs1 index of the instruction in ID.
- id_rs2, in, 5: rs2 index of the instruction in ID.
- id_use_rs1, in, 1: instruction in ID reads rs1.
- id_use_rs2, in, 1: instruction in ID reads rs2.
- ex_written_reg, in, 5: ID/EXE destination register.
- ex_reg_write, in, 1: ID/EXE register-write enable.
- ex_data_to_reg, in, 2: ID/EXE write-back source select.
- ex_branch, in, 2: ID/EXE branch field; nonzero means a control-transfer instruction.
- ex_mispredict, in, 1: EXE resolved the branch opposite to the prediction.
- mem_req, in, 1: MEM stage is accessing data memory.
- dmem_ready, in, 1: data memory completes the access this cycle.
- PC_CE, out, 1: PC register enable.
- IF_ID_CE, out, 1: IF/ID register enable.
- IF_ID_flush, out, 1: IF/ID loads a NOP.
- ID_EXE_CE, out, 1: ID/EXE register enable.
- ID_EXE_dstall, out, 1: ID/EXE loads a bubble (data hazard).
- ID_EXE_cstall, out, 1: ID/EXE loads a bubble (control hazard).
- EXE_MEM_CE, out, 1: EXE/MEM register enable.
- MEM_WB_CE, out, 1: MEM/WB register enable.
- redirect, out, 1: PC mux selects ID/EXE fallback_PC.
- mem_timeout, out, 1: sticky memory-timeout flag.
- cnt_load_use, out, CNT_W: load-use stall cycles.
- cnt_flush, out, CNT_W: mispredict events.
- cnt_mem_wait, out, CNT_W: memory-wait cycles.

Behaviour:
- States: RUN, FLUSH, MEM_WAIT. Reset enters RUN.
- Control outputs are combinational from state and inputs, sampled by the pipeline registers at the next edge. Counters and flags are registered.
- While rst_n is low:
  - all CE outputs = 0; flush, stall and redirect outputs = 0;
  - mem_timeout = 0; all counters = 0; flush_cnt = 0; wait_cnt = 0.
- Priority per cycle: memwait > mispredict > load-use > normal.
- memwait = mem_req & ~dmem_ready.
  - Every CE = 0; dstall = cstall = flush = redirect = 0. The whole pipeline freezes, including a pending mispredict or load-use.
  - State goes to MEM_WAIT. wait_cnt increments (8-bit).
  - mem_timeout sets when wait_cnt reaches MEM_TIMEOUT and stays set until reset.
  - In MEM_WAIT, dmem_ready = 1 returns to RUN in the same cycle with all CEs = 1.
  - cnt_mem_wait increments every frozen cycle.
- mispredict = ex_mispredict & (ex_branch != 0), and no memwait.
  - redirect = 1, IF_ID_flush = 1, ID_EXE_cstall = 1; all CEs = 1.
  - cnt_flush increments by 1.
  - If FLUSH_CYCLES > 1: enter FLUSH with flush_cnt = FLUSH_CYCLES-1.
- FLUSH state:
  - IF_ID_flush = 1; PC_CE = 1; redirect = 0; flush_cnt decrements each cycle.
  - Returns to RUN when flush_cnt reaches 1.
  - A new mispredict during FLUSH reloads flush_cnt.
  - Load-use detection is suppressed, because the ID contents are wrong-path.
- load_use = ex_reg_write & (ex_data_to_reg == LOAD_SEL) & (ex_written_reg != 0) & ((id_use_rs1 & id_rs1 == ex_written_reg) | (id_use_rs2 & id_rs2 == ex_written_reg)).
  - PC_CE = 0, IF_ID_CE = 0, ID_EXE_dstall = 1.
  - EXE_MEM_CE = MEM_WB_CE = 1.
  - Exactly one bubble is inserted per load, because the next cycle's ID/EXE holds the bubble.
  - cnt_load_use increments.
- Normal: all CEs = 1; all other control outputs = 0.
- Counters saturate at all-ones and never wrap.
- Asserting rst_n low mid-FLUSH or mid-MEM_WAIT aborts immediately to the reset values above.
- A register index of x0 never causes a stall.

Test Plan:
- Reset: rst_n = 0 for 3 cycles, then release with no hazards -> all CEs = 1, all counters = 0, state RUN.
- Load-use: ID/EXE holds lw x5 (ex_data_to_reg = 2'b01, ex_reg_write = 1); ID holds add x6,x5,x1 -> one cycle of PC_CE = 0, IF_ID_CE = 0, ID_EXE_dstall = 1; next cycle normal; cnt_load_use = 1. The same case with destination x0 -> no stall.
- Mispredict: ex_branch = 2'b01, ex_mispredict = 1 -> redirect, IF_ID_flush and ID_EXE_cstall each high for 1 cycle; cnt_flush = 1. With FLUSH_CYCLES = 3 -> IF_ID_flush stays high 3 cycles and redirect only in the first.
- Mem wait: mem_req = 1 with dmem_ready low for 4 cycles -> all CEs = 0 for 4 cycles; cnt_mem_wait = 4. A mispredict asserted during the wait is applied only in the cycle dmem_ready = 1.
- Timeout: MEM_TIMEOUT = 5 and dmem_ready held low -> mem_timeout rises after the 5th wait cycle and stays high after dmem_ready returns; it clears only on rst_n.
- Simultaneous events and saturation: load-use and mispredict in the same cycle -> mispredict wins with no dstall. With CNT_W = 4 and 20 load-use events -> cnt_load_use = 15.
